cycle_period_analyzer: RTL

- Downstream consumer of the encoder-cycle statistics RAM (32-bit wide, 64 deep).
- On each zero-mark rising edge, sweeps the RAM once and reduces the previous revolution to summary values:
  - tooth count and count check
  - revolution period (sum of tooth periods)
  - min and max tooth period, each with its index
  - speed-in-window flag
- Results are published with a one-cycle valid strobe to the motor/speed-control logic.
- RAM contract:
  - Address 0 holds the tooth count N of the last revolution.
  - Addresses 1..N hold the per-tooth periods, in i_clk_50m cycles.

---
 rtl/cycle_period_analyzer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/cycle_period_analyzer.sv
// Reduces one revolution of encoder tooth periods from the statistics RAM
// into tooth count, revolution period, min/max tooth period and speed flags.
module cycle_period_analyzer #(
  parameter int unsigned TOOTH_NUM = 60,
  parameter int unsigned START_DLY = 2,
  parameter logic [31:0] REV_MIN   = 32'd200000,
  parameter logic [31:0] REV_MAX   = 32'd400000
) (
  input  logic        i_clk_50m,
  input  logic        i_rst_n,
  input  logic        i_zero_sign,
  input  logic        i_motor_state,
  output logic [5:0]  o_ram_raddr,
  output logic        o_ram_ren,
  input  logic [31:0] i_ram_rdata,
  output logic        o_busy,
  output logic        o_result_valid,
  output logic [7:0]  o_tooth_num,
  output logic [31:0] o_rev_period,
  output logic [31:0] o_min_period,
  output logic [5:0]  o_min_idx,
  output logic [31:0] o_max_period,
  output logic [5:0]  o_max_idx,
  output logic        o_cnt_err,
  output logic        o_ovr_err,
  output logic        o_speed_ok
);

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 8;
  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RD_CNT, S_CHK, S_SWEEP, S_DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sync1, r_sync2;
  logic            w_edge;
  logic [CW-1:0]   r_dly;
  logic [NW-1:0]   r_n;
  logic            r_skip;
  logic            r_dvalid;
  logic [AW-1:0]   r_didx;
  logic [DW-1:0]   r_sum, r_min, r_max;
  logic [AW-1:0]   r_min_idx, r_max_idx;
  logic            r_ovr;
  logic            w_n_bad;
  logic [DW:0]     w_sum_ext;
  logic            w_speed;

  logic            r_ren, w_ren_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_valid, w_valid_nxt;
  logic [NW-1:0]   r_tooth;
  logic [DW-1:0]   r_rev, r_min_o, r_max_o;
  logic [AW-1:0]   r_min_idx_o, r_max_idx_o;
  logic            r_cnt_err, r_ovr_err, r_speed_ok;

  assign w_edge    = r_sync1 & ~r_sync2;
  assign w_n_bad   = (i_ram_rdata[7:0] == NW'(0)) || (i_ram_rdata[7:0] > NW'(63));
  assign w_sum_ext = {1'b0, r_sum} + {1'b0, i_ram_rdata};
  assign w_speed   = i_motor_state & (r_sum >= REV_MIN) & (r_sum <= REV_MAX) & ~r_skip;

  // Two-flop synchronizer for the asynchronous zero mark
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_zero_sign;
      r_sync2 <= r_sync1;
    end
  end

  // State register
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; an invalid count still takes one drain cycle in
  // SWEEP so both paths share the same pipeline depth
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_edge) w_state_nxt = S_WAIT;
      S_WAIT:   if (r_dly <= CW'(1)) w_state_nxt = S_RD_CNT;
      S_RD_CNT: w_state_nxt = S_CHK;
      S_CHK:    w_state_nxt = S_SWEEP;
      S_SWEEP:  if (r_skip || (r_dvalid && (r_didx == r_n[AW-1:0]))) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered control outputs
  always_comb begin
    w_ren_nxt   = 1'b0;
    w_addr_nxt  = r_addr;
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_valid_nxt = (r_state == S_DONE);
    case (r_state)
      S_WAIT: begin
        if (w_state_nxt == S_RD_CNT) begin
          w_ren_nxt  = 1'b1;
          w_addr_nxt = AW'(0);
        end
      end
      S_CHK: begin
        if (!w_n_bad) begin
          w_ren_nxt  = 1'b1;
          w_addr_nxt = AW'(1);
        end
      end
      S_SWEEP: begin
        if (r_ren && (r_addr != r_n[AW-1:0])) begin
          w_ren_nxt  = 1'b1;
          w_addr_nxt = r_addr + AW'(1);
        end
      end
      default: ;
    endcase
  end

  // Control output registers
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ren   <= 1'b0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_ren   <= w_ren_nxt;
      r_addr  <= w_addr_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Sweep datapath: delay counter, read pipeline tag, accumulators
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dly     <= '0;
      r_n       <= '0;
      r_skip    <= 1'b0;
      r_dvalid  <= 1'b0;
      r_didx    <= '0;
      r_sum     <= '0;
      r_min     <= '0;
      r_max     <= '0;
      r_min_idx <= '0;
      r_max_idx <= '0;
    end else begin
      r_dvalid <= (r_state == S_SWEEP) & r_ren;
      r_didx   <= r_addr;
      if ((r_state == S_IDLE) && w_edge) r_dly <= CW'(START_DLY);
      else if (r_state == S_WAIT)        r_dly <= r_dly - CW'(1);
      if (r_state == S_CHK) begin
        r_n       <= i_ram_rdata[NW-1:0];
        r_skip    <= w_n_bad;
        r_sum     <= '0;
        r_min     <= w_n_bad ? '0 : '1;
        r_max     <= '0;
        r_min_idx <= '0;
        r_max_idx <= '0;
      end else if ((r_state == S_SWEEP) && r_dvalid) begin
        r_sum <= w_sum_ext[DW] ? '1 : w_sum_ext[DW-1:0];
        if (i_ram_rdata < r_min) begin
          r_min     <= i_ram_rdata;
          r_min_idx <= r_didx;
        end
        if (i_ram_rdata > r_max) begin
          r_max     <= i_ram_rdata;
          r_max_idx <= r_didx;
        end
      end
    end
  end

  // Overrun flag: zero edge seen while a sweep is already running
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n)                             r_ovr <= 1'b0;
    else if (r_state == S_DONE)               r_ovr <= 1'b0;
    else if (w_edge && (r_state != S_IDLE))   r_ovr <= 1'b1;
  end

  // Published results, held until the next DONE
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tooth     <= '0;
      r_rev       <= '0;
      r_min_o     <= '0;
      r_min_idx_o <= '0;
      r_max_o     <= '0;
      r_max_idx_o <= '0;
      r_cnt_err   <= 1'b0;
      r_ovr_err   <= 1'b0;
      r_speed_ok  <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_tooth     <= r_n;
      r_rev       <= r_sum;
      r_min_o     <= r_min;
      r_min_idx_o <= r_min_idx;
      r_max_o     <= r_max;
      r_max_idx_o <= r_max_idx;
      r_cnt_err   <= (r_n != NW'(TOOTH_NUM));
      r_ovr_err   <= r_ovr | w_edge;
      r_speed_ok  <= w_speed;
    end
  end

  assign o_ram_raddr    = r_addr;
  assign o_ram_ren      = r_ren;
  assign o_busy         = r_busy;
  assign o_result_valid = r_valid;
  assign o_tooth_num    = r_tooth;
  assign o_rev_period   = r_rev;
  assign o_min_period   = r_min_o;
  assign o_min_idx      = r_min_idx_o;
  assign o_max_period   = r_max_o;
  assign o_max_idx      = r_max_idx_o;
  assign o_cnt_err      = r_cnt_err;
  assign o_ovr_err      = r_ovr_err;
  assign o_speed_ok     = r_speed_ok;

endmodule
